// File: rtl/uart_reg_pkg.sv
// uart_reg_pkg: shared types and constants for the UART register-access master
package uart_reg_pkg;
    typedef enum logic [2:0] {IDLE, TX_CMD, TX_HI, TX_LO, RX_HI, RX_LO, DONE} state_t;
    localparam int CMD_WRITE_BIT = 7;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 12;
    localparam logic [1:0] ERR_OK = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_FRAME = 2'd2;
    // 8N1 frame, transmitted LSB first: start bit in [0], stop bit in [9]
    function automatic logic [9:0] frame(input logic [7:0] b);
        return {1'b1, b, 1'b0};
    endfunction
endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: free-running bit-period down-counter, reloadable for a full or a half bit
module uart_bit_timer #(
    parameter int BIT_CYC = 868
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic load_half,
    output logic tick
);
    localparam int W = $clog2(BIT_CYC);
    localparam logic [W-1:0] FULL = W'(BIT_CYC - 1);
    localparam logic [W-1:0] HALF = W'(BIT_CYC / 2 - 1);
    logic [W-1:0] cnt_q, cnt_d;
    // tick lands BIT_CYC (or BIT_CYC/2) cycles after a load, then every BIT_CYC cycles
    always_comb begin
        cnt_d = load_half ? HALF : (load || cnt_q == '0) ? FULL : cnt_q - 1'b1;
        tick = !load && !load_half && cnt_q == '0;
    end
    // counter register
    always_ff @(posedge clk or posedge reset)
        if (reset) cnt_q <= FULL;
        else cnt_q <= cnt_d;
endmodule

// File: rtl/uart_reg_master.sv
// uart_reg_master: serialises register requests as 8N1 UART frames and collects read replies
module uart_reg_master
    import uart_reg_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int BAUD        = 115_200,
    parameter int TIMEOUT_CYC = 2_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [1:0]        rsp_err,
    output logic              uart_txd,
    input  logic              uart_rxd
);
    localparam int BIT_CYC = CLK_HZ / BAUD;
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    state_t state_q, state_d;
    logic [9:0] tx_sh_q, tx_sh_d;
    logic [3:0] tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d, rx_hi_q, rx_hi_d;
    logic [7:0] rx_sh_q, rx_sh_d, cmd;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [1:0] err_q, err_d;
    logic [TO_W-1:0] to_q, to_d;
    logic wr_q, wr_d, rx_busy_q, rx_busy_d, rsp_valid_q, rsp_valid_d, req_ready_q, req_ready_d;
    logic rx_s1_q, rx_s2_q, rx_prev_q, rx_fall, rx_in, tx_load, tx_tick, rx_load_half, rx_tick;

    uart_bit_timer #(.BIT_CYC(BIT_CYC)) u_tx_timer (
        .clk(clk), .reset(reset), .load(tx_load), .load_half(1'b0), .tick(tx_tick)
    );
    uart_bit_timer #(.BIT_CYC(BIT_CYC)) u_rx_timer (
        .clk(clk), .reset(reset), .load(1'b0), .load_half(rx_load_half), .tick(rx_tick)
    );

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err = err_q;
    assign uart_txd = tx_sh_q[0];

    // request FSM: transmit cmd/data frames, then for reads hunt for and assemble the reply
    always_comb begin
        state_d = state_q;
        tx_sh_d = tx_sh_q;
        tx_bit_d = tx_bit_q;
        wr_d = wr_q;
        wdata_d = wdata_q;
        rx_busy_d = rx_busy_q;
        rx_bit_d = rx_bit_q;
        rx_sh_d = rx_sh_q;
        rx_hi_d = rx_hi_q;
        to_d = to_q + 1'b1;
        rsp_valid_d = 1'b0;
        rdata_d = rdata_q;
        err_d = err_q;
        tx_load = 1'b0;
        rx_load_half = 1'b0;
        rx_fall = rx_prev_q && !rx_s2_q;
        rx_in = state_q == RX_HI || state_q == RX_LO;
        cmd = {4'h0, req_addr};
        cmd[CMD_WRITE_BIT] = req_write;
        if (state_q == IDLE) begin
            if (req_valid && req_ready_q) begin
                state_d = TX_CMD;
                tx_sh_d = frame(cmd);
                tx_bit_d = '0;
                wr_d = req_write;
                wdata_d = req_wdata;
                tx_load = 1'b1;
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end else if (!rx_in) begin
            if (tx_tick && tx_bit_q != 4'd9) begin
                tx_bit_d = tx_bit_q + 1'b1;
                tx_sh_d = {1'b1, tx_sh_q[9:1]};
            end else if (tx_tick) begin
                tx_bit_d = '0;
                tx_sh_d = '1;
                if (state_q == TX_CMD && wr_q) begin
                    state_d = TX_HI;
                    tx_sh_d = frame({4'h0, wdata_q[11:8]});
                end else if (state_q == TX_HI) begin
                    state_d = TX_LO;
                    tx_sh_d = frame(wdata_q[7:0]);
                end else if (state_q == TX_LO) begin
                    state_d = DONE;
                    rsp_valid_d = 1'b1;
                    err_d = ERR_OK;
                end else begin
                    state_d = RX_HI;
                    rx_busy_d = 1'b0;
                    to_d = '0;
                end
            end
        end else if (to_q == TO_LAST) begin
            state_d = DONE;
            rsp_valid_d = 1'b1;
            err_d = ERR_TIMEOUT;
            rx_busy_d = 1'b0;
        end else if (!rx_busy_q) begin
            if (rx_fall) begin
                rx_load_half = 1'b1;
                rx_busy_d = 1'b1;
                rx_bit_d = '0;
            end
        end else if (rx_tick) begin
            if (rx_bit_q == 4'd0) begin
                // start bit must still be low at mid-bit, otherwise it was a glitch
                rx_busy_d = !rx_s2_q;
                rx_bit_d = 4'd1;
            end else if (rx_bit_q != 4'd9) begin
                rx_sh_d = {rx_s2_q, rx_sh_q[7:1]};
                rx_bit_d = rx_bit_q + 1'b1;
            end else begin
                rx_busy_d = 1'b0;
                if (!rx_s2_q) begin
                    state_d = DONE;
                    rsp_valid_d = 1'b1;
                    err_d = ERR_FRAME;
                end else if (state_q == RX_HI) begin
                    state_d = RX_LO;
                    rx_hi_d = rx_sh_q[3:0];
                end else begin
                    state_d = DONE;
                    rsp_valid_d = 1'b1;
                    err_d = ERR_OK;
                    rdata_d = {rx_hi_q, rx_sh_q};
                end
            end
        end
        req_ready_d = state_d == IDLE;
    end

    // rxd is asynchronous: two-flop synchroniser plus a delayed copy for edge detection
    always_ff @(posedge clk or posedge reset)
        if (reset) {rx_s1_q, rx_s2_q, rx_prev_q} <= 3'b111;
        else {rx_s1_q, rx_s2_q, rx_prev_q} <= {uart_rxd, rx_s1_q, rx_s2_q};

    // state and datapath registers; tx shifter resets to ones so txd idles high at once
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q <= IDLE;
            tx_sh_q <= '1;
            tx_bit_q <= '0;
            wr_q <= 1'b0;
            wdata_q <= '0;
            rx_busy_q <= 1'b0;
            rx_bit_q <= '0;
            rx_sh_q <= '0;
            rx_hi_q <= '0;
            to_q <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q <= '0;
            err_q <= ERR_OK;
            req_ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_sh_q <= tx_sh_d;
            tx_bit_q <= tx_bit_d;
            wr_q <= wr_d;
            wdata_q <= wdata_d;
            rx_busy_q <= rx_busy_d;
            rx_bit_q <= rx_bit_d;
            rx_sh_q <= rx_sh_d;
            rx_hi_q <= rx_hi_d;
            to_q <= to_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q <= rdata_d;
            err_q <= err_d;
            req_ready_q <= req_ready_d;
        end
endmodule

// File: tb/tb_uart_reg_master.sv
// tb_uart_reg_master: randomized and directed checks of the UART register master against a byte-level model
module tb_uart_reg_master;
    localparam int TO = 1000;
    logic clk = 1'b0, reset = 1'b1, req_valid = 1'b0, req_write = 1'b0, uart_rxd = 1'b1;
    logic [3:0] req_addr = '0;
    logic [11:0] req_wdata = '0;
    logic req_ready, rsp_valid, uart_txd;
    logic [11:0] rsp_rdata;
    logic [1:0] rsp_err;
    int n_chk = 0, n_fail = 0, cyc = 0, hs_cyc = 0, rsp_cyc = 0;
    logic [8:0] tx_q[$];
    logic [11:0] exp_rdata = '0, got_rdata;
    logic [1:0] got_err;
    logic got_rsp;

    uart_reg_master #(.CLK_HZ(1_000_000), .BAUD(100_000), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .uart_txd(uart_txd), .uart_rxd(uart_rxd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // txd decoder: samples each bit at its middle, queues {stop, data}
    initial begin : tx_mon
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (uart_txd === 1'b0) begin
                repeat (5) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (10) @(negedge clk);
                    b[i] = uart_txd;
                end
                repeat (10) @(negedge clk);
                tx_q.push_back({uart_txd, b});
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rxd = f[i];
            repeat (10) @(negedge clk);
        end
        uart_rxd = 1'b1;
    endtask

    task automatic start_req(input logic w, input logic [3:0] a, input logic [11:0] d);
        int n = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = w;
        req_addr = a;
        req_wdata = d;
        while (req_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_chk++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL handshake: req_ready=%b required 1", req_ready);
        end
        @(negedge clk);
        hs_cyc = cyc;
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr = 4'($urandom);
        req_wdata = 12'($urandom);
        n_chk++;
        if (req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_drop: req_ready=%b required 0", req_ready);
        end
    endtask

    task automatic wait_rsp(input int limit);
        int n = 0;
        got_rsp = 1'b0;
        while (!got_rsp && n < limit) begin
            @(negedge clk);
            n++;
            if (rsp_valid === 1'b1) begin
                got_rsp = 1'b1;
                rsp_cyc = cyc;
                got_err = rsp_err;
                got_rdata = rsp_rdata;
            end
        end
        n_chk++;
        if (!got_rsp) begin
            n_fail++;
            $display("FAIL rsp_wait: no rsp_valid within %0d cycles", limit);
        end else begin
            @(negedge clk);
            n_chk++;
            if (rsp_valid !== 1'b0 || rsp_rdata !== got_rdata) begin
                n_fail++;
                $display("FAIL rsp_pulse: rsp_valid=%b rdata=%h required 0 and %h held", rsp_valid, rsp_rdata, got_rdata);
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++;
        if (uart_txd !== 1'b1 || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: txd=%b ready=%b rsp_valid=%b required 1 0 0", uart_txd, req_ready, rsp_valid);
        end
        reset = 1'b0;
        @(negedge clk);
        n_chk++;
        if (req_ready !== 1'b1 || rsp_rdata !== 12'h0 || rsp_err !== 2'd0 || uart_txd !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: ready=%b rdata=%h err=%0d txd=%b required 1 000 0 1", req_ready, rsp_rdata, rsp_err, uart_txd);
        end
        exp_rdata = '0;
    endtask

    task automatic test_write(input logic [3:0] a, input logic [11:0] d);
        int exp_b[3];
        exp_b[0] = 128 + a;
        exp_b[1] = d / 256;
        exp_b[2] = d % 256;
        tx_q.delete();
        start_req(1'b1, a, d);
        wait_rsp(400);
        n_chk++;
        if (got_rsp && (rsp_cyc - hs_cyc != 300 || got_err !== 2'd0)) begin
            n_fail++;
            $display("FAIL write_rsp: latency=%0d err=%0d required 300 0", rsp_cyc - hs_cyc, got_err);
        end
        n_chk++;
        if (tx_q.size() != 3) begin
            n_fail++;
            $display("FAIL write_frames: %0d frames required 3", tx_q.size());
        end
        for (int i = 0; i < 3 && i < tx_q.size(); i++) begin
            n_chk++;
            if (tx_q[i] !== 9'(256 + exp_b[i])) begin
                n_fail++;
                $display("FAIL write_byte%0d: got {stop,data}=%h required %h", i, tx_q[i], 9'(256 + exp_b[i]));
            end
        end
    endtask

    // mode 0: normal reply, 1: silent, 2: hi byte with bad stop, 3: glitch then normal reply
    task automatic test_read(input logic [3:0] a, input logic [7:0] hi, input logic [7:0] lo, input int mode);
        int n = 0;
        logic [1:0] exp_err;
        exp_err = mode == 1 ? 2'd1 : mode == 2 ? 2'd2 : 2'd0;
        tx_q.delete();
        start_req(1'b0, a, 12'($urandom));
        while (tx_q.size() == 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (10) @(negedge clk);
        fork
            begin
                if (mode == 3) begin
                    uart_rxd = 1'b0;
                    repeat (3) @(negedge clk);
                    uart_rxd = 1'b1;
                    repeat (12) @(negedge clk);
                end
                if (mode != 1) send_byte(hi, mode != 2);
                if (mode == 0 || mode == 3) send_byte(lo, 1'b1);
            end
            wait_rsp(mode == 1 ? TO + 200 : 400);
        join
        if (exp_err == 2'd0) exp_rdata = 12'((hi % 16) * 256 + lo);
        n_chk++;
        if (got_rsp && (got_err !== exp_err || got_rdata !== exp_rdata)) begin
            n_fail++;
            $display("FAIL read_rsp(mode %0d): err=%0d rdata=%h required %0d %h", mode, got_err, got_rdata, exp_err, exp_rdata);
        end
        n_chk++;
        if (tx_q.size() != 1 || tx_q[0] !== 9'(256 + a)) begin
            n_fail++;
            $display("FAIL read_cmd: %0d frames first=%h required 1 frame %h", tx_q.size(), tx_q.size() ? tx_q[0] : 9'h0, 9'(256 + a));
        end
        if (mode == 1) begin
            n_chk++;
            if (got_rsp && rsp_cyc - hs_cyc != 100 + TO) begin
                n_fail++;
                $display("FAIL timeout_time: rsp at %0d cycles required %0d", rsp_cyc - hs_cyc, 100 + TO);
            end
        end
    endtask

    task automatic test_reset_mid_tx;
        start_req(1'b1, 4'($urandom), 12'($urandom));
        repeat (104) @(negedge clk);
        n_chk++;
        if (uart_txd !== 1'b0) begin
            n_fail++;
            $display("FAIL hi_start_bit: txd=%b required 0", uart_txd);
        end
        reset = 1'b1;
        #1;
        n_chk++;
        if (uart_txd !== 1'b1 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: txd=%b ready=%b required 1 0", uart_txd, req_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_chk++;
        if (req_ready !== 1'b1 || rsp_rdata !== 12'h0 || uart_txd !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset: ready=%b rdata=%h txd=%b required 1 000 1", req_ready, rsp_rdata, uart_txd);
        end
        exp_rdata = '0;
        repeat (110) @(negedge clk);
        test_write(4'($urandom), 12'($urandom));
    endtask

    task automatic test_random;
        for (int k = 0; k < 8; k++) begin
            if ($urandom_range(1) == 1) test_write(4'($urandom), 12'($urandom));
            else test_read(4'($urandom), 8'($urandom), 8'($urandom), 0);
        end
    endtask

    initial begin
        test_reset();
        test_write(4'd3, 12'hABC);
        test_read(4'd5, 8'h07, 8'h21, 0);
        test_read(4'd9, 8'h00, 8'h00, 1);
        test_read(4'd2, 8'h01, 8'h55, 2);
        test_read(4'd12, 8'hF3, 8'h5A, 3);
        test_reset_mid_tx();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
